apb_master: RTL and testbench

- Bridges the SoC's internal valid/ready request interface onto the APB bus as a single-outstanding-transfer APB initiator.
- Accepts one read or write request, runs the APB SETUP and ACCESS phases, and waits for PREADY, bounded by a timeout.
- Returns read data, write completion and error status as single-cycle pulses.
- Sits between a DMA or CPU-side requester and the APB fabric; it pairs with the team's APB slave bridge on the far side.

---
 rtl/apb_pkg.sv | 17 +
 rtl/apb_master.sv | 131 +++++++++++++
 tb/tb_apb_master.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and defaults for the APB initiator
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } apb_mst_state_t;

    localparam logic APB_READ  = 1'b0;
    localparam logic APB_WRITE = 1'b1;

    localparam int APB_ADDR_WIDTH     = 32;
    localparam int APB_DATA_WIDTH     = 32;
    localparam int APB_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/apb_master.sv
// rtl/apb_master.sv - single-outstanding APB initiator bridged from a valid/ready request port
module apb_master
    import apb_pkg::*;
#(
    parameter int addr_width     = APB_ADDR_WIDTH,
    parameter int data_width     = APB_DATA_WIDTH,
    parameter int timeout_cycles = APB_TIMEOUT_CYCLES
) (
    input  logic                  i_clk_apb,
    input  logic                  i_rstn_apb,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [addr_width-1:0] i_addr,
    input  logic                  i_rd0_wr1,
    input  logic [data_width-1:0] i_wr_data,
    output logic                  o_rd_valid,
    output logic [data_width-1:0] o_rd_data,
    output logic                  o_wr_done,
    output logic                  o_err,
    output logic                  o_psel,
    output logic                  o_penable,
    output logic                  o_pwrite,
    output logic [addr_width-1:0] o_paddr,
    output logic [data_width-1:0] o_pwdata,
    input  logic [data_width-1:0] i_prdata,
    input  logic                  i_pready,
    input  logic                  i_pslverr
);

    localparam bit TIMEOUT_EN = (timeout_cycles > 0);
    localparam int CNT_W      = TIMEOUT_EN ? $clog2(timeout_cycles + 1) : 1;
    // Abort fires at the end of the timeout_cycles-th ACCESS cycle without PREADY
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_EN ? timeout_cycles - 1 : 0);

    apb_mst_state_t state, state_nxt;
    logic [CNT_W-1:0]      wait_cnt, wait_cnt_nxt;
    logic                  psel_nxt, penable_nxt, pwrite_nxt;
    logic [addr_width-1:0] paddr_nxt;
    logic [data_width-1:0] pwdata_nxt, rd_data_nxt;
    logic                  rd_valid_nxt, wr_done_nxt, err_nxt;
    logic                  done, timed_out;

    assign o_ready = (state == IDLE);

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        psel_nxt     = o_psel;
        penable_nxt  = o_penable;
        pwrite_nxt   = o_pwrite;
        paddr_nxt    = o_paddr;
        pwdata_nxt   = o_pwdata;
        rd_data_nxt  = o_rd_data;
        rd_valid_nxt = 1'b0;
        wr_done_nxt  = 1'b0;
        err_nxt      = 1'b0;
        done         = 1'b0;
        timed_out    = 1'b0;

        case (state)
            IDLE: begin
                if (i_valid) begin
                    state_nxt  = SETUP;
                    psel_nxt   = 1'b1;
                    paddr_nxt  = i_addr;
                    pwrite_nxt = i_rd0_wr1;
                    pwdata_nxt = (i_rd0_wr1 == APB_WRITE) ? i_wr_data : '0;
                end
            end
            SETUP: begin
                state_nxt    = ACCESS;
                penable_nxt  = 1'b1;
                wait_cnt_nxt = '0;
            end
            ACCESS: begin
                // PREADY wins over a timeout reached in the same cycle
                if (i_pready) begin
                    done = 1'b1;
                end else if (TIMEOUT_EN && (wait_cnt == CNT_LIMIT)) begin
                    done      = 1'b1;
                    timed_out = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (done) begin
            state_nxt   = IDLE;
            psel_nxt    = 1'b0;
            penable_nxt = 1'b0;
            err_nxt     = timed_out | i_pslverr;
            if (o_pwrite == APB_WRITE) begin
                wr_done_nxt = 1'b1;
            end else begin
                rd_valid_nxt = 1'b1;
                rd_data_nxt  = timed_out ? '0 : i_prdata;
            end
        end
    end

    always_ff @(posedge i_clk_apb or negedge i_rstn_apb) begin
        if (!i_rstn_apb) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            o_psel     <= 1'b0;
            o_penable  <= 1'b0;
            o_pwrite   <= 1'b0;
            o_paddr    <= '0;
            o_pwdata   <= '0;
            o_rd_data  <= '0;
            o_rd_valid <= 1'b0;
            o_wr_done  <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            state      <= state_nxt;
            wait_cnt   <= wait_cnt_nxt;
            o_psel     <= psel_nxt;
            o_penable  <= penable_nxt;
            o_pwrite   <= pwrite_nxt;
            o_paddr    <= paddr_nxt;
            o_pwdata   <= pwdata_nxt;
            o_rd_data  <= rd_data_nxt;
            o_rd_valid <= rd_valid_nxt;
            o_wr_done  <= wr_done_nxt;
            o_err      <= err_nxt;
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - directed table-driven bench for apb_master
module tb_apb_master;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rstn;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_addr;
    logic        i_rd0_wr1;
    logic [31:0] i_wr_data;
    logic        o_rd_valid;
    logic [31:0] o_rd_data;
    logic        o_wr_done;
    logic        o_err;
    logic        o_psel;
    logic        o_penable;
    logic        o_pwrite;
    logic [31:0] o_paddr;
    logic [31:0] o_pwdata;
    logic [31:0] i_prdata;
    logic        i_pready;
    logic        i_pslverr;

    apb_master #(
        .addr_width    (32),
        .data_width    (32),
        .timeout_cycles(TIMEOUT)
    ) dut (
        .i_clk_apb (clk),
        .i_rstn_apb(rstn),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_addr    (i_addr),
        .i_rd0_wr1 (i_rd0_wr1),
        .i_wr_data (i_wr_data),
        .o_rd_valid(o_rd_valid),
        .o_rd_data (o_rd_data),
        .o_wr_done (o_wr_done),
        .o_err     (o_err),
        .o_psel    (o_psel),
        .o_penable (o_penable),
        .o_pwrite  (o_pwrite),
        .o_paddr   (o_paddr),
        .o_pwdata  (o_pwdata),
        .i_prdata  (i_prdata),
        .i_pready  (i_pready),
        .i_pslverr (i_pslverr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic        slverr;
        logic [31:0] prdata;
        logic        exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t        vecs [7];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cur_vec  = -1;
    logic [31:0] last_rd  = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (vec %0d): got %0h expected %0h", name, cur_vec, act, exp);
        end
    endtask

    task automatic do_xfer(input vec_t v);
        bit to;
        to = (TIMEOUT > 0) && (v.waits >= TIMEOUT);
        @(negedge clk);
        chk("idle ready", 32'(o_ready), 32'd1);
        chk("prior pulse cleared", 32'({o_rd_valid, o_wr_done}), 32'd0);
        i_valid   = 1'b1;
        i_addr    = v.addr;
        i_rd0_wr1 = v.wr;
        i_wr_data = v.wdata;
        i_pready  = 1'b0;
        i_pslverr = 1'b0;
        i_prdata  = 32'h0;
        @(negedge clk);
        i_valid   = 1'b0;
        i_addr    = ~v.addr;
        i_wr_data = ~v.wdata;
        i_rd0_wr1 = ~v.wr;
        chk("setup psel/penable/ready", 32'({o_psel, o_penable, o_ready}), 32'b100);
        chk("setup paddr", o_paddr, v.addr);
        chk("setup pwrite", 32'(o_pwrite), 32'(v.wr));
        chk("setup pwdata", o_pwdata, v.wr ? v.wdata : 32'h0);
        // PREADY raised during SETUP must not shorten the transfer
        i_pready  = 1'b1;
        i_pslverr = v.slverr;
        i_prdata  = v.prdata;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            chk("access psel/penable/ready/pulse", 32'({o_psel, o_penable, o_ready, o_rd_valid | o_wr_done}), 32'b1100);
            chk("access paddr stable", o_paddr, v.addr);
            chk("access pwdata stable", o_pwdata, v.wr ? v.wdata : 32'h0);
            i_pready = (k >= v.waits);
            if (k == v.waits || (to && k == TIMEOUT - 1)) break;
        end
        @(negedge clk);
        chk("done rd_valid", 32'(o_rd_valid), 32'(!v.wr));
        chk("done wr_done", 32'(o_wr_done), 32'(v.wr));
        chk("done err", 32'(o_err), 32'(v.exp_err));
        chk("done psel/penable/ready", 32'({o_psel, o_penable, o_ready}), 32'b001);
        chk("done rd_data", o_rd_data, v.wr ? last_rd : v.exp_rd);
        chk("done paddr held", o_paddr, v.addr);
        if (!v.wr) last_rd = v.exp_rd;
        i_pready  = 1'b0;
        i_pslverr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0,  1'b0, 32'h0,         1'b0, 32'h0};
        vecs[1] = '{1'b0, 32'h0000_0020, 32'h0,         3,  1'b0, 32'h1234_5678, 1'b0, 32'h1234_5678};
        vecs[2] = '{1'b1, 32'h0000_0030, 32'hCAFE_F00D, 0,  1'b1, 32'h0,         1'b1, 32'h0};
        vecs[3] = '{1'b0, 32'h0000_0040, 32'h0,         99, 1'b0, 32'hAAAA_5555, 1'b1, 32'h0};
        vecs[4] = '{1'b0, 32'h0000_0044, 32'h0,         15, 1'b0, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D};
        vecs[5] = '{1'b0, 32'h0000_0048, 32'h0,         1,  1'b1, 32'h55AA_55AA, 1'b1, 32'h55AA_55AA};
        vecs[6] = '{1'b1, 32'h0000_004C, 32'h0F0F_0F0F, 2,  1'b0, 32'h0,         1'b0, 32'h0};

        rstn = 1'b0; i_valid = 1'b0; i_addr = '0; i_rd0_wr1 = 1'b0; i_wr_data = '0;
        i_prdata = '0; i_pready = 1'b0; i_pslverr = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset outputs", 32'({o_psel, o_penable, o_pwrite, o_rd_valid, o_wr_done, o_err, o_ready}), 32'b0000001);
        chk("reset paddr", o_paddr, 32'h0);
        chk("reset pwdata", o_pwdata, 32'h0);
        chk("reset rd_data", o_rd_data, 32'h0);
        rstn = 1'b1;

        for (int i = 0; i < 7; i++) begin
            cur_vec = i;
            do_xfer(vecs[i]);
        end

        // Back-to-back: i_valid held high, write/read alternating, one accept per 3 cycles
        cur_vec = 100;
        @(negedge clk);
        i_valid = 1'b1; i_rd0_wr1 = 1'b1; i_addr = 32'h80; i_wr_data = 32'h11;
        i_pready = 1'b1; i_pslverr = 1'b0; i_prdata = 32'h7777_0000;
        for (int c = 0; c <= 12; c++) begin
            chk("b2b ready", 32'(o_ready), 32'((c % 3) == 0));
            chk("b2b psel", 32'(o_psel), 32'((c % 3) != 0));
            chk("b2b penable", 32'(o_penable), 32'((c % 3) == 2));
            if ((c % 3) == 1) chk("b2b pwrite", 32'(o_pwrite), 32'(((c / 3) % 2) == 0));
            if ((c % 3) == 0 && c > 0) begin
                chk("b2b wr_done", 32'(o_wr_done), 32'((((c / 3) - 1) % 2) == 0));
                chk("b2b rd_valid", 32'(o_rd_valid), 32'((((c / 3) - 1) % 2) == 1));
            end
            i_rd0_wr1 = ((((c + 1) / 3) % 2) == 0);
            if (c == 12) i_valid = 1'b0;
            else @(negedge clk);
        end
        last_rd = 32'h7777_0000;
        @(negedge clk);
        i_pready = 1'b0;

        // Async reset while in ACCESS drops the transfer with no completion
        cur_vec = 200;
        @(negedge clk);
        i_valid = 1'b1; i_rd0_wr1 = 1'b0; i_addr = 32'h60;
        @(negedge clk);
        i_valid = 1'b0;
        @(negedge clk);
        chk("rst pre access", 32'({o_psel, o_penable}), 32'b11);
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("rst async outputs", 32'({o_psel, o_penable, o_rd_valid, o_wr_done, o_err, o_ready}), 32'b000001);
        chk("rst async paddr", o_paddr, 32'h0);
        @(negedge clk);
        i_pready = 1'b1;
        rstn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst no pulse", 32'({o_psel, o_rd_valid, o_wr_done}), 32'b000);
        end
        i_pready = 1'b0;
        last_rd = 32'h0;
        cur_vec = 201;
        do_xfer(vecs[1]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
